// File: rtl/c1541_gcr_stream.sv
// c1541_gcr_stream: GCR bit-stream engine between the track buffer RAM and the 1541 logic.
// Read mode serialises track bytes MSB first, flags SYNC runs and completed bytes.
// Write mode shifts bytes from the 1541 logic back into the track buffer one bit at a
// time using one-hot per-bit write enables.
module c1541_gcr_stream #(
   parameter int CLK_PER_UNIT = 2,
   parameter int ADDR_W       = 13,
   parameter int SYNC_LEN     = 10,
   parameter int TRACK_BITS_0 = 50000,
   parameter int TRACK_BITS_1 = 53336,
   parameter int TRACK_BITS_2 = 57144,
   parameter int TRACK_BITS_3 = 61536
) (
   input  logic              clk32,
   input  logic              reset,
   input  logic              mtr,
   input  logic              ram_ready,
   input  logic              mode,
   input  logic              soe,
   input  logic              wps_n,
   input  logic [1:0]        speed_zone,
   input  logic [7:0]        din,
   output logic [7:0]        dout,
   output logic              sync_n,
   output logic              byte_n,
   output logic [ADDR_W-1:0] byte_addr,
   input  logic [7:0]        ram_do,
   output logic [7:0]        ram_di,
   output logic [7:0]        ram_be,
   output logic              ram_we
);

   localparam int BA_W = ADDR_W + 3;
   localparam int PS_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
   // The shift register is at least a byte wide so dout can always be taken from it.
   localparam int SR_W = (SYNC_LEN > 8) ? SYNC_LEN : 8;

   localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_UNIT - 1);
   localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
   localparam logic [BA_W-1:0] BA_ONE  = BA_W'(1);
   localparam logic [BA_W-1:0] LAST_0  = BA_W'(TRACK_BITS_0 - 1);
   localparam logic [BA_W-1:0] LAST_1  = BA_W'(TRACK_BITS_1 - 1);
   localparam logic [BA_W-1:0] LAST_2  = BA_W'(TRACK_BITS_2 - 1);
   localparam logic [BA_W-1:0] LAST_3  = BA_W'(TRACK_BITS_3 - 1);

   // One-hot enable for the bit at position pos of a byte, bit 0 of the stream is the MSB.
   function automatic logic [7:0] bit_enable(input logic [2:0] pos);
      bit_enable = 8'h80 >> pos;
   endfunction

   logic            run_s;
   logic            unit_tick_s;
   logic            unit_last_s;
   logic            phase_tick_s;
   logic            bs_s;
   logic            be_s;
   logic            load_s;
   logic            pending_s;
   logic            ram_bit_s;
   logic            sync_next_n_s;
   logic [SR_W-1:0] sr_next_s;
   logic [BA_W-1:0] track_last_s;

   logic [PS_W-1:0] presc_r;
   logic [3:0]      unit_r;
   logic [1:0]      phase_r;
   logic [1:0]      zone_r;
   logic [BA_W-1:0] bit_addr_r;
   logic [SR_W-1:0] sr_r;
   logic [7:0]      wsr_r;
   logic [2:0]      bit_count_r;
   logic            byte_pending_r;
   logic            mode_r;
   logic [7:0]      dout_r;
   logic            sync_n_r;
   logic            byte_n_r;
   logic [7:0]      ram_di_r;
   logic [7:0]      ram_be_r;
   logic            ram_we_r;

   assign run_s         = mtr & ram_ready;
   assign unit_tick_s   = run_s && (presc_r == PS_LAST);
   assign unit_last_s   = (unit_r == (4'd15 - {2'b00, zone_r}));
   assign phase_tick_s  = unit_tick_s && unit_last_s;
   assign bs_s          = phase_tick_s && (phase_r == 2'd1);
   assign be_s          = phase_tick_s && (phase_r == 2'd3);
   assign ram_bit_s     = ram_do[3'd7 - bit_addr_r[2:0]];
   assign sr_next_s     = {sr_r[SR_W-2:0], ram_bit_s};
   assign sync_next_n_s = ~(&sr_next_s[SYNC_LEN-1:0]);

   assign dout      = dout_r;
   assign sync_n    = sync_n_r;
   assign byte_n    = byte_n_r;
   assign byte_addr = bit_addr_r[BA_W-1:3];
   assign ram_di    = ram_di_r;
   assign ram_be    = ram_be_r;
   assign ram_we    = ram_we_r;

   // Last valid bit address for the zone being sampled at this bit end.
   always_comb begin
      track_last_s = LAST_0;
      case (speed_zone)
         2'd0:    track_last_s = LAST_0;
         2'd1:    track_last_s = LAST_1;
         2'd2:    track_last_s = LAST_2;
         2'd3:    track_last_s = LAST_3;
         default: track_last_s = LAST_0;
      endcase
   end

   // Write mode loads a new byte at a bit end once all 8 bits have gone out.
   always_comb begin
      load_s = 1'b0;
      if (!mode && (bit_count_r == 3'd0)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
      pending_s = byte_pending_r | load_s;
   end

   // Bit-cell timebase: prescaler, unit and phase counters; zone latched at each bit end.
   always_ff @(posedge clk32) begin
      if (reset) begin
         presc_r <= {PS_W{1'b0}};
         unit_r  <= 4'd0;
         phase_r <= 2'd0;
         zone_r  <= 2'd0;
      end else if (!run_s) begin
         presc_r <= {PS_W{1'b0}};
         unit_r  <= 4'd0;
         phase_r <= 2'd0;
      end else begin
         if (unit_tick_s) begin
            presc_r <= {PS_W{1'b0}};
            if (unit_last_s) begin
               unit_r <= 4'd0;
            end else begin
               unit_r <= unit_r + 4'd1;
            end
         end else begin
            presc_r <= presc_r + PS_ONE;
         end
         if (phase_tick_s) begin
            phase_r <= phase_r + 2'd1;
         end
         if (be_s) begin
            zone_r <= speed_zone;
         end
      end
   end

   // Stream datapath: shift registers, bit/byte counting, SYNC, byte-ready and bit address.
   always_ff @(posedge clk32) begin
      if (reset) begin
         bit_addr_r     <= {BA_W{1'b0}};
         sr_r           <= {SR_W{1'b0}};
         wsr_r          <= 8'h00;
         bit_count_r    <= 3'd0;
         byte_pending_r <= 1'b0;
         mode_r         <= mode;
         dout_r         <= 8'h00;
         sync_n_r       <= 1'b1;
         byte_n_r       <= 1'b1;
      end else if (!run_s) begin
         byte_n_r <= 1'b1;
      end else begin
         mode_r <= mode;
         if (bs_s) begin
            byte_n_r <= 1'b1;
            if (mode) begin
               sr_r     <= sr_next_s;
               sync_n_r <= sync_next_n_s;
               if (!sync_next_n_s) begin
                  bit_count_r <= 3'd0;
               end else begin
                  bit_count_r <= bit_count_r + 3'd1;
                  if (bit_count_r == 3'd7) begin
                     dout_r         <= sr_next_s[7:0];
                     byte_pending_r <= 1'b1;
                  end
               end
            end else begin
               wsr_r       <= {wsr_r[6:0], 1'b0};
               bit_count_r <= bit_count_r + 3'd1;
               sync_n_r    <= 1'b1;
            end
         end
         if (be_s) begin
            if (bit_addr_r >= track_last_s) begin
               bit_addr_r <= {BA_W{1'b0}};
            end else begin
               bit_addr_r <= bit_addr_r + BA_ONE;
            end
            if (load_s) begin
               wsr_r <= din;
            end
            if (pending_s) begin
               byte_pending_r <= 1'b0;
               if (soe) begin
                  byte_n_r <= 1'b0;
               end
            end
         end
         // A mode switch restarts byte framing; placed last so it overrides same-cycle updates.
         if (mode != mode_r) begin
            if (mode) begin
               sr_r <= {SR_W{1'b0}};
            end else begin
               bit_count_r <= 3'd0;
               sync_n_r    <= 1'b1;
            end
         end
      end
   end

   // Track buffer write port: one-cycle pulse after each write-mode bit strobe.
   always_ff @(posedge clk32) begin
      if (reset) begin
         ram_we_r <= 1'b0;
         ram_di_r <= 8'h00;
         ram_be_r <= 8'h00;
      end else if (bs_s && !mode && wps_n) begin
         ram_we_r <= 1'b1;
         ram_di_r <= {8{wsr_r[7]}};
         ram_be_r <= bit_enable(bit_addr_r[2:0]);
      end else begin
         ram_we_r <= 1'b0;
         ram_di_r <= 8'h00;
         ram_be_r <= 8'h00;
      end
   end

endmodule

// File: doc/c1541_gcr_stream.md
# c1541_gcr_stream

Parametrised GCR bit-stream engine for the 1541 drive model: a successor to the fixed read-only GCR shifter. It serialises track-buffer RAM into a GCR bit stream for the 1541 logic, with byte-ready and SYNC detection. It also performs true bit-granular writes back into the track buffer using per-bit byte enables. It sits between the track buffer RAM and the 1541 VIA/logic glue, clocked from the 32 MHz system clock.

## Interface
- CLK_PER_UNIT, 2: clk32 cycles per 16 MHz drive-crystal tick.
- ADDR_W, 13: track buffer byte-address width; bit address is ADDR_W+3 bits.
- SYNC_LEN, 10: consecutive 1 bits required to flag SYNC (2..16).
- TRACK_BITS_0..3, 50000/53336/57144/61536: track length in bits for speed zones 0..3 (each ≤ 2^(ADDR_W+3)).
- clk32  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mtr  in  1  spindle motor on.
- ram_ready  in  1  track buffer valid; engine runs only when mtr & ram_ready (= run).
- mode  in  1  1 = read, 0 = write.
- soe  in  1  byte-ready output enable.
- wps_n  in  1  write protect, low = protected.
- speed_zone  in  2  bit-cell rate select.
- din  in  8  byte to write, from 1541 logic.
- dout  out  8  last completed read byte.
- sync_n  out  1  low while SYNC detected.
- byte_n  out  1  byte-ready strobe, active low.
- byte_addr  out  ADDR_W  track buffer byte address (bit_addr[ADDR_W+2:3]).
- ram_do  in  8  track buffer read data for byte_addr, combinational/valid same cycle.
- ram_di  out  8  write data.
- ram_be  out  8  per-bit write enable, one-hot.
- ram_we  out  1  write strobe, one-cycle pulse.

## Operation
- Timebase: prescaler 0..CLK_PER_UNIT-1 → unit tick; unit counter 0..(15-speed_zone) → phase tick; phase counter 0..3. A bit cell is 4·(16-speed_zone)·CLK_PER_UNIT clk32 cycles: 128/120/112/104 at defaults.
- Bit strobe (BS): phase 1→2 transition. Bit end (BE): phase 3→0 transition.
- run low: prescaler, unit and phase counters held at 0; bit_addr and shift registers held; byte_n=1; ram_we=0.
- Speed-zone sampling: speed_zone is sampled only at BE; mid-cell changes take effect next cell.
- Read (mode=1), at BS:
  - shift register sr[SYNC_LEN-1:0] ← {sr, ram_do[7-bit_addr[2:0]]}.
  - sync_n = ~(&sr) (registered, updates the cycle after BS).
  - While sync_n=0, bit_count forced to 0; otherwise bit_count increments mod 8.
  - When bit_count goes 7→0 without sync, dout ← sr[7:0] and byte_pending set.
- Write (mode=0), at BS:
  - write shift register wsr MSB is the current bit. If wps_n=1: ram_di ← {8{wsr[7]}}, ram_be ← 1<<(7-bit_addr[2:0]), ram_we=1 for exactly one cycle. wps_n=0 suppresses ram_we; all counters still advance.
  - wsr ← wsr<<1; bit_count increments mod 8.
  - sync_n held 1 in write mode.
- Write at BE: if bit_count==0, wsr ← din and byte_pending set.
- Mode change read→write: bit_count cleared to 0 immediately, so the first BE after the switch loads din. Write→read: sr cleared to 0.
- byte_n: at BE with byte_pending and soe=1, byte_n←0 and byte_pending cleared. byte_n←1 at the next BS (low for 2 phases). With soe=0, byte_pending is cleared at BE and byte_n stays 1.
- bit_addr at BE: if bit_addr ≥ TRACK_BITS_[zone]-1 → 0 (this also covers a zone change leaving the address out of range); else +1.

## Timing
- Reset values: dout=0, sync_n=1, byte_n=1, byte_addr=0, ram_di=0, ram_be=0, ram_we=0; all counters, bit_addr, sr and wsr = 0; byte_pending=0.
- ram_do is sampled on the BS cycle. byte_addr changes only on BE cycles, so it is stable ≥ 2 phases before each BS.
- ram_we, ram_di and ram_be are registered, asserted the cycle after BS, and deasserted the following cycle.
- dout and sync_n are registered one cycle after BS. byte_n falls one cycle after BE.
- Reset mid-cell or mid-write wins over all events: ram_we drops in the same cycle reset is sampled, and no partial byte is flagged.
- run dropping mid-cell: if ram_we is already high, the pulse completes, then the block freezes. On resume, the current cell restarts from phase 0.

## Test plan
- Zone timing: speed_zone=0, run=1. Measure BS-to-BS spacing at 128 clk32 cycles; at zone 3, 104 cycles; a zone change mid-cell applies only from the next cell.
- Read byte: RAM holds 0xFF,0xFF,0x52 from addr 0 in read mode. Expect sync_n low from the 10th 1-bit; sync_n high after the first 0; after 8 more bits dout=0x52 and byte_n low for 2 phases; with soe=0, byte_n stays 1.
- Write path: mode=0, wps_n=1, din=0xA5 at bit_addr 3. Expect 8 ram_we pulses with ram_be = 0x10,0x08,0x04,0x02,0x01,0x80,0x40,0x20 and bit values 1,0,1,0,0,1,0,1. byte_addr advances 0→1 after the 5th bit. Repeat with wps_n=0: zero ram_we pulses.
- Wrap: zone 0, bit_addr forced to 49999. Next BE yields bit_addr 0, byte_addr 0. Switching zone 3→0 at bit_addr 55000 wraps to 0 at the next BE.
- Stall and reset: drop mtr mid-cell; counters and byte_addr frozen, byte_n=1, ram_we=0. Assert reset during a write byte; all outputs return to reset values in the next cycle.
- Mode switch: read→write mid-byte. bit_count becomes 0, the next BE loads din=0x3C, and byte_n pulses if soe=1.
